// File: rtl/spi_target.sv
// SPI mode-0 target, 8-bit, MSB first. All pins are oversampled in the clk domain.
// Defining SPI_TARGET_IRQ_EN adds a registered, level-sensitive irq output.
module spi_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] TX_FILL     = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       unload,
    input  logic [7:0] datain,
    output logic [7:0] dataout,
    output logic       rx_valid,
    output logic       tx_empty,
    output logic       overrun,
    input  logic       sclk,
    input  logic       ssn,
    input  logic       mosi,
    output logic       miso,
`ifdef SPI_TARGET_IRQ_EN
    output logic       miso_oe,
    output logic       irq
`else
    output logic       miso_oe
`endif
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ssn_sync_q, ssn_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ssn_prev_q, ssn_prev_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [7:0]             tx_buf_q, tx_buf_d;
    logic                   tx_empty_q, tx_empty_d;
    logic [7:0]             dataout_q, dataout_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   overrun_q, overrun_d;

    logic sclk_s, ssn_s, mosi_s;
    logic sclk_rise, sclk_fall;
    logic frame_start, deselect, selected;
    logic consume, byte_done;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        ssn_sync_d  = {ssn_sync_q[SYNC_STAGES-2:0], ssn};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};

        sclk_s = sclk_sync_q[SYNC_STAGES-1];
        ssn_s  = ssn_sync_q[SYNC_STAGES-1];
        mosi_s = mosi_sync_q[SYNC_STAGES-1];

        sclk_prev_d = sclk_s;
        ssn_prev_d  = ssn_s;

        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        frame_start = ~ssn_s & ssn_prev_q;
        deselect    = ssn_s & ~ssn_prev_q;
        selected    = ~ssn_s;

        // The fall after a complete byte reloads exactly like a frame start.
        consume   = frame_start | (selected & ~frame_start & sclk_fall & (bit_cnt_q == 3'd0));
        byte_done = selected & ~frame_start & sclk_rise & (bit_cnt_q == 3'd7);

        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_empty_d = tx_empty_q;
        dataout_d  = dataout_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;

        if (unload) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        if (consume) begin
            tx_shift_d = tx_empty_q ? TX_FILL : tx_buf_q;
            tx_empty_d = 1'b1;
        end

        // A load in the same cycle as a consume refills the buffer behind it.
        if (load) begin
            tx_buf_d   = datain;
            tx_empty_d = 1'b0;
        end

        if (frame_start) begin
            bit_cnt_d = 3'd0;
        end else if (selected) begin
            if (sclk_rise) begin
                rx_shift_d = {rx_shift_q[6:0], mosi_s};
                bit_cnt_d  = bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
                if (!rx_valid_q || unload) begin
                    dataout_d  = {rx_shift_q[6:0], mosi_s};
                    rx_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            if (sclk_fall && (bit_cnt_q != 3'd0)) begin
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
        end

        if (deselect) begin
            bit_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            ssn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ssn_prev_q  <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            tx_buf_q    <= 8'h00;
            tx_empty_q  <= 1'b1;
            dataout_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ssn_sync_q  <= ssn_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ssn_prev_q  <= ssn_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_empty_q  <= tx_empty_d;
            dataout_q   <= dataout_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // miso is driven low whenever the synchronized select is inactive.
    assign miso     = selected & tx_shift_q[7];
    assign miso_oe  = selected;
    assign dataout  = dataout_q;
    assign rx_valid = rx_valid_q;
    assign tx_empty = tx_empty_q;
    assign overrun  = overrun_q;

`ifdef SPI_TARGET_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = rx_valid_q | overrun_q | (tx_empty_q & selected);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: table of single-byte frames plus hand-written
// sequences for latency, underflow/overrun, abort, coincident unload and reset.
module tb_spi_target;
    logic       clk;
    logic       rst_n;
    logic       load;
    logic       unload;
    logic [7:0] datain;
    logic [7:0] dataout;
    logic       rx_valid;
    logic       tx_empty;
    logic       overrun;
    logic       sclk;
    logic       ssn;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
`ifdef SPI_TARGET_IRQ_EN
    logic       irq;
`endif

    int errors = 0;
    int checks = 0;

    spi_target #(.SYNC_STAGES(2), .TX_FILL(8'hFF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .unload   (unload),
        .datain   (datain),
        .dataout  (dataout),
        .rx_valid (rx_valid),
        .tx_empty (tx_empty),
        .overrun  (overrun),
        .sclk     (sclk),
        .ssn      (ssn),
        .mosi     (mosi),
        .miso     (miso),
`ifdef SPI_TARGET_IRQ_EN
        .miso_oe  (miso_oe),
        .irq      (irq)
`else
        .miso_oe  (miso_oe)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       do_unload;
        logic       do_load;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_miso;
        logic [7:0] exp_dout;
        logic       exp_rxv;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[4];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic pulse_load(input logic [7:0] d);
        datain = d;
        load = 1'b1;
        wait_clk(1);
        load = 1'b0;
    endtask

    task automatic pulse_unload();
        unload = 1'b1;
        wait_clk(1);
        unload = 1'b0;
    endtask

    // Shifts the first n bits of mo MSB first at clk/8; miso captured at each rise.
    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = mo[7-i];
            wait_clk(4);
            sclk = 1'b1;
            mi[7-i] = miso;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    task automatic sel();
        ssn = 1'b0;
        wait_clk(4);
    endtask

    task automatic desel();
        wait_clk(2);
        ssn = 1'b1;
        wait_clk(4);
    endtask

    logic [7:0] mi;
    logic [7:0] mi2;

    initial begin
        vecs[0] = '{do_unload: 1'b1, do_load: 1'b1, tx: 8'h3C, mo: 8'h5A,
                    exp_miso: 8'h3C, exp_dout: 8'h5A, exp_rxv: 1'b1, exp_ov: 1'b0};
        vecs[1] = '{do_unload: 1'b1, do_load: 1'b0, tx: 8'h00, mo: 8'h96,
                    exp_miso: 8'hFF, exp_dout: 8'h96, exp_rxv: 1'b1, exp_ov: 1'b0};
        vecs[2] = '{do_unload: 1'b0, do_load: 1'b1, tx: 8'h81, mo: 8'h0F,
                    exp_miso: 8'h81, exp_dout: 8'h96, exp_rxv: 1'b1, exp_ov: 1'b1};
        vecs[3] = '{do_unload: 1'b1, do_load: 1'b1, tx: 8'h00, mo: 8'hF0,
                    exp_miso: 8'h00, exp_dout: 8'hF0, exp_rxv: 1'b1, exp_ov: 1'b0};

        rst_n = 1'b0; load = 1'b0; unload = 1'b0; datain = 8'h00;
        sclk = 1'b0; ssn = 1'b1; mosi = 1'b0;

        // Reset with random pin activity
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sclk = 1'($urandom_range(0, 1));
            ssn  = 1'($urandom_range(0, 1));
            mosi = 1'($urandom_range(0, 1));
        end
        wait_clk(1);
        check("rst_dataout", 32'(dataout), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_tx_empty", 32'(tx_empty), 32'h1);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_miso_oe", 32'(miso_oe), 32'h0);
        check("rst_miso", 32'(miso), 32'h0);
        sclk = 1'b0; ssn = 1'b1; mosi = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);

        // Receive 0xA5 and check rx_valid latency against the 8th pin rise
        sel();
        check("sel_miso_oe", 32'(miso_oe), 32'h1);
        spi_bits(8'hA5, 7, mi);
        mosi = 1'b1;
        wait_clk(4);
        sclk = 1'b1;
        wait_clk(2);
        check("rxv_lat_early", 32'(rx_valid), 32'h0);
        wait_clk(1);
        check("rxv_lat_on", 32'(rx_valid), 32'h1);
        check("rx_a5", 32'(dataout), 32'hA5);
        wait_clk(1);
        sclk = 1'b0;
        wait_clk(4);
        desel();
        check("desel_miso_oe", 32'(miso_oe), 32'h0);
        pulse_unload();
        wait_clk(1);
        check("unload_rxv", 32'(rx_valid), 32'h0);
        check("unload_hold_dout", 32'(dataout), 32'hA5);

        // Table of single-byte frames
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].do_unload) pulse_unload();
            if (vecs[v].do_load) begin
                pulse_load(vecs[v].tx);
                check($sformatf("v%0d_tx_full", v), 32'(tx_empty), 32'h0);
            end
            sel();
            check($sformatf("v%0d_tx_empty_sel", v), 32'(tx_empty), 32'h1);
            spi_bits(vecs[v].mo, 8, mi);
            desel();
            check($sformatf("v%0d_miso", v), 32'(mi), 32'(vecs[v].exp_miso));
            check($sformatf("v%0d_dataout", v), 32'(dataout), 32'(vecs[v].exp_dout));
            check($sformatf("v%0d_rx_valid", v), 32'(rx_valid), 32'(vecs[v].exp_rxv));
            check($sformatf("v%0d_overrun", v), 32'(overrun), 32'(vecs[v].exp_ov));
        end

        // Underflow and overrun: two bytes, no load, no unload
        pulse_unload();
        sel();
        spi_bits(8'h11, 8, mi);
        spi_bits(8'h22, 8, mi2);
        desel();
        check("uf_miso_b1", 32'(mi), 32'hFF);
        check("uf_miso_b2", 32'(mi2), 32'hFF);
        check("ov_set", 32'(overrun), 32'h1);
        check("ov_dout", 32'(dataout), 32'h11);
        pulse_unload();
        wait_clk(1);
        check("ov_clr", 32'(overrun), 32'h0);
        check("ov_rxv_clr", 32'(rx_valid), 32'h0);

        // Abort after 4 rises, then a clean frame
        sel();
        spi_bits(8'hF0, 4, mi);
        desel();
        wait_clk(4);
        check("abort_rxv", 32'(rx_valid), 32'h0);
        check("abort_ov", 32'(overrun), 32'h0);
        sel();
        spi_bits(8'hC3, 8, mi);
        desel();
        check("after_abort_dout", 32'(dataout), 32'hC3);
        check("after_abort_rxv", 32'(rx_valid), 32'h1);

        // unload lands in the same cycle as byte-complete
        sel();
        spi_bits(8'h7E, 7, mi);
        mosi = 1'b0;
        wait_clk(4);
        sclk = 1'b1;
        wait_clk(2);
        unload = 1'b1;
        wait_clk(1);
        unload = 1'b0;
        check("coinc_rxv", 32'(rx_valid), 32'h1);
        check("coinc_ov", 32'(overrun), 32'h0);
        check("coinc_dout", 32'(dataout), 32'h7E);
        wait_clk(1);
        sclk = 1'b0;
        wait_clk(4);
        desel();

`ifdef SPI_TARGET_IRQ_EN
        check("irq_rx", 32'(irq), 32'h1);
        pulse_load(8'h42);
        pulse_unload();
        wait_clk(3);
        check("irq_idle", 32'(irq), 32'h0);
        sel();
        wait_clk(2);
        check("irq_tx_empty_sel", 32'(irq), 32'h1);
        desel();
        wait_clk(2);
        check("irq_desel", 32'(irq), 32'h0);
`endif

        // Reset mid-byte with a pending tx byte
        sel();
        pulse_load(8'h55);
        spi_bits(8'hAA, 4, mi);
        sclk = 1'b1;
        rst_n = 1'b0;
        wait_clk(2);
        check("mid_rst_dataout", 32'(dataout), 32'h00);
        check("mid_rst_rxv", 32'(rx_valid), 32'h0);
        check("mid_rst_tx_empty", 32'(tx_empty), 32'h1);
        check("mid_rst_ov", 32'(overrun), 32'h0);
        check("mid_rst_miso_oe", 32'(miso_oe), 32'h0);
        check("mid_rst_miso", 32'(miso), 32'h0);
        sclk = 1'b0; ssn = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        sel();
        spi_bits(8'h3D, 8, mi);
        desel();
        check("post_rst_dout", 32'(dataout), 32'h3D);
        check("post_rst_miso", 32'(mi), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
